// File: rtl/mio_mem_responder_if.sv
// CPU memory/IO port bundle: request, direction, address, write data,
// with read data and the one-cycle ready pulse coming back.
interface mio_mem_responder_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        mio_ready;

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, mio_ready
  );

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, mio_ready
  );
endinterface

// File: rtl/mio_mem_responder.sv
// Far end of the CPU memory/IO handshake: word RAM plus LED/switch IO, with
// WAIT_CYCLES wait states. Define MIO_TIMER_EN to add a cycle counter at 0xF0000008.
module mio_mem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  mio_mem_responder_if.slave  bus,
  input  logic [7:0]          sw_in,
  output logic [7:0]          led_out
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_RELEASE} state_t;

  localparam logic [25:0] IO_LED = 26'd0;
  localparam logic [25:0] IO_SW  = 26'd1;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept;
  logic        enter_resp;
  logic [31:2] a_addr;
  logic        a_we;
  logic [31:0] a_wdata;
  logic [31:2] acc_addr;
  logic        acc_we;
  logic [31:0] rd_data;
  logic        commit;
  logic        unused_addr_lsb;

  logic [31:0] ram [0:2**ADDR_W-1];

  assign unused_addr_lsb = ^bus.cpu_addr[1:0];

  // With zero wait states the response is formed on the accepting edge,
  // before the latches hold the request, so decode from the live bus then.
  assign acc_addr   = (state == ST_IDLE) ? bus.cpu_addr[31:2] : a_addr;
  assign acc_we     = (state == ST_IDLE) ? bus.cpu_we         : a_we;
  assign enter_resp = (state != ST_RESP) && (state_nxt == ST_RESP);
  assign commit     = (state == ST_RESP) && a_we;

`ifdef MIO_TIMER_EN
  localparam logic [25:0] IO_TIMER = 26'd2;
  logic [31:0] timer, timer_lat, acc_timer;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer     <= '0;
      timer_lat <= '0;
    end else begin
      timer <= timer + 32'd1;
      if (accept) timer_lat <= timer;
    end
  end

  assign acc_timer = (state == ST_IDLE) ? timer : timer_lat;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.cpu_req) begin
          accept = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nxt = ST_RESP;
          end else begin
            state_nxt = ST_WAIT;
            cnt_nxt   = 4'(WAIT_CYCLES);
          end
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt - 4'd1;
        if (cnt <= 4'd1) state_nxt = ST_RESP;
      end
      ST_RESP:    state_nxt = ST_RELEASE;
      ST_RELEASE: if (!bus.cpu_req) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    if (acc_addr[31:28] == 4'hF) begin
      case (acc_addr[27:2])
        IO_LED:   rd_data = {24'b0, led_out};
        IO_SW:    rd_data = {24'b0, sw_in};
`ifdef MIO_TIMER_EN
        IO_TIMER: rd_data = acc_timer;
`endif
        default:  rd_data = '0;
      endcase
    end else begin
      rd_data = ram[acc_addr[ADDR_W+1:2]];
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      a_addr        <= '0;
      a_we          <= 1'b0;
      a_wdata       <= '0;
      bus.mio_ready <= 1'b0;
      bus.cpu_rdata <= '0;
      led_out       <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      bus.mio_ready <= enter_resp;
      if (accept) begin
        a_addr  <= bus.cpu_addr[31:2];
        a_we    <= bus.cpu_we;
        a_wdata <= bus.cpu_wdata;
      end
      if (enter_resp) bus.cpu_rdata <= acc_we ? 32'd0 : rd_data;
      if (commit && a_addr[31:28] == 4'hF && a_addr[27:2] == IO_LED)
        led_out <= a_wdata[7:0];
    end
  end

  // NOTE: the RAM array has no reset; contents survive reset and a
  // reset-free block lets it map onto memory macros.
  always_ff @(posedge clk) begin
    if (commit && a_addr[31:28] != 4'hF) ram[a_addr[ADDR_W+1:2]] <= a_wdata;
  end

endmodule

// File: tb/tb_mio_mem_responder.sv
// Directed bench for mio_mem_responder: one instance with two wait states,
// one with none; table of RAM/IO accesses plus hand-written corner sequences.
module tb_mio_mem_responder;

  logic       clk;
  logic       reset;
  logic [7:0] sw;
  logic [7:0] led2, led0;

  mio_mem_responder_if bus2 ();
  mio_mem_responder_if bus0 ();

  mio_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut2 (
    .clk(clk), .reset(reset), .bus(bus2.slave), .sw_in(sw), .led_out(led2)
  );

  mio_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0.slave), .sw_in(sw), .led_out(led0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [7:0]  sw;
    logic [31:0] exp_rdata;
    logic [7:0]  exp_led;
  } vec_t;

  vec_t vecs[12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One access on the two-wait-state port; returns the ready cycle (0 = timeout)
  // and the read data seen with the pulse. Inputs are scrambled after acceptance.
  task automatic acc2(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output int lat);
    lat   = 0;
    rdata = '0;
    @(negedge clk);
    bus2.cpu_req   = 1'b1;
    bus2.cpu_we    = we;
    bus2.cpu_addr  = addr;
    bus2.cpu_wdata = wdata;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        bus2.cpu_we    = ~we;
        bus2.cpu_addr  = 32'h0000_0FFC;
        bus2.cpu_wdata = 32'h5A5A_5A5A;
      end
      if (bus2.mio_ready) begin
        lat   = c;
        rdata = bus2.cpu_rdata;
        break;
      end
    end
    bus2.cpu_req = 1'b0;
    @(negedge clk);
    check("ready_one_cycle", {31'b0, bus2.mio_ready}, 32'd0);
    @(negedge clk);
  endtask

  logic [31:0] rd, r1, r2;
  int          lat, pulses, first;

  initial begin
    vecs[0]  = '{1'b1, 32'h0000_0008, 32'h1234_5678, 8'h00, 32'h0000_0000, 8'h00};
    vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0000_0000, 8'h00, 32'h1234_5678, 8'h00};
    vecs[2]  = '{1'b1, 32'hF000_0000, 32'hFFFF_FFA5, 8'h00, 32'h0000_0000, 8'hA5};
    vecs[3]  = '{1'b0, 32'hF000_0000, 32'h0000_0000, 8'h00, 32'h0000_00A5, 8'hA5};
    vecs[4]  = '{1'b0, 32'hF000_0004, 32'h0000_0000, 8'h3C, 32'h0000_003C, 8'hA5};
    vecs[5]  = '{1'b1, 32'hF000_0004, 32'h0000_0012, 8'h3C, 32'h0000_0000, 8'hA5};
    vecs[6]  = '{1'b0, 32'hF000_0010, 32'h0000_0000, 8'h3C, 32'h0000_0000, 8'hA5};
    vecs[7]  = '{1'b1, 32'h0000_1004, 32'hCAFE_F00D, 8'h3C, 32'h0000_0000, 8'hA5};
    vecs[8]  = '{1'b0, 32'h0000_0007, 32'h0000_0000, 8'h3C, 32'hCAFE_F00D, 8'hA5};
    vecs[9]  = '{1'b1, 32'h0000_0010, 32'h1111_2222, 8'h3C, 32'h0000_0000, 8'hA5};
    vecs[10] = '{1'b0, 32'h0000_0010, 32'h0000_0000, 8'h3C, 32'h1111_2222, 8'hA5};
    vecs[11] = '{1'b1, 32'hF000_000C, 32'h0000_00FF, 8'h3C, 32'h0000_0000, 8'hA5};

    reset = 1'b0;
    sw    = 8'h00;
    bus2.cpu_req = 1'b0; bus2.cpu_we = 1'b0; bus2.cpu_addr = '0; bus2.cpu_wdata = '0;
    bus0.cpu_req = 1'b0; bus0.cpu_we = 1'b0; bus0.cpu_addr = '0; bus0.cpu_wdata = '0;
    repeat (3) @(negedge clk);
    check("reset_ready", {31'b0, bus2.mio_ready}, 32'd0);
    check("reset_rdata", bus2.cpu_rdata, 32'd0);
    check("reset_led",   {24'b0, led2}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < 12; i++) begin
      sw = vecs[i].sw;
      acc2(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, lat);
      check($sformatf("v%0d_latency", i), lat, 32'd3);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_led", i), {24'b0, led2}, {24'b0, vecs[i].exp_led});
    end
    check("rdata_hold", bus2.cpu_rdata, 32'd0);

    // Reset in the middle of a write's wait states must drop the write.
    @(negedge clk);
    bus2.cpu_req = 1'b1; bus2.cpu_we = 1'b1;
    bus2.cpu_addr = 32'h0000_0010; bus2.cpu_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    check("abort_wait_ready", {31'b0, bus2.mio_ready}, 32'd0);
    reset = 1'b0;
    bus2.cpu_req = 1'b0;
    pulses = 0;
    repeat (2) begin
      @(negedge clk);
      if (bus2.mio_ready) pulses++;
    end
    check("abort_led_cleared", {24'b0, led2}, 32'd0);
    reset = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (bus2.mio_ready) pulses++;
    end
    check("abort_no_pulse", pulses, 32'd0);
    acc2(1'b0, 32'h0000_0010, 32'h0, rd, lat);
    check("abort_latency", lat, 32'd3);
    check("abort_prior_data", rd, 32'h1111_2222);

    // Zero wait states, request held high: one pulse per access.
    @(negedge clk);
    bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b1;
    bus0.cpu_addr = 32'h0000_0020; bus0.cpu_wdata = 32'h0BAD_CAFE;
    pulses = 0; first = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus0.mio_ready) begin
        pulses++;
        if (first == 0) first = c;
      end
    end
    check("w0_write_pulses", pulses, 32'd1);
    check("w0_write_latency", first, 32'd1);
    bus0.cpu_req = 1'b0;
    repeat (2) @(negedge clk);
    bus0.cpu_req = 1'b1; bus0.cpu_we = 1'b0;
    pulses = 0; first = 0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (bus0.mio_ready) begin
        pulses++;
        if (first == 0) first = c;
      end
    end
    check("w0_read_pulses", pulses, 32'd1);
    check("w0_read_latency", first, 32'd1);
    check("w0_read_rdata", bus0.cpu_rdata, 32'h0BAD_CAFE);
    bus0.cpu_req = 1'b0;

    // Timer reads accepted 20 cycles apart (6-cycle access + 14 idle).
    acc2(1'b0, 32'hF000_0008, 32'h0, r1, lat);
    repeat (14) @(negedge clk);
    acc2(1'b0, 32'hF000_0008, 32'h0, r2, lat);
`ifdef MIO_TIMER_EN
    check("timer_delta", r2 - r1, 32'd20);
    check("timer_nonzero", {31'b0, (r1 != 32'd0)}, 32'd1);
`else
    check("timer_read1", r1, 32'd0);
    check("timer_read2", r2, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mio_mem_responder.md
Name: mio_mem_responder

Overview:
- Bus-side responder for the multicycle CPU's memory/IO port: the far end of the CPU_MIO / mem_w / MIO_ready handshake.
- Decodes each CPU access to either a word-addressed RAM or a small memory-mapped IO register block.
- Inserts a configurable number of wait states, then returns read data and a one-cycle ready pulse.
- Sits between MCPU_v1 and the board peripherals; replaces the hand-driven Data_in/MIO_ready stimulus used in CPU benches.

Parameters:
- ADDR_W, 10: RAM word-address width; RAM depth is 2**ADDR_W words of 32 bits.
- WAIT_CYCLES, 2: wait states inserted before the ready pulse; legal range 0..15.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  access request (CPU_MIO).
- cpu_we  in  1  1 = write, 0 = read (mem_w).
- cpu_addr  in  32  byte address (Addr_out).
- cpu_wdata  in  32  write data (Data_out).
- cpu_rdata  out  32  read data to CPU (Data_in); registered.
- mio_ready  out  1  one-cycle completion pulse (MIO_ready); registered.
- sw_in  in  8  board switches; read-only IO.
- led_out  out  8  LED register; registered.

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; mio_ready=0; cpu_rdata=0; led_out=0; wait counter=0.
  - RAM contents are not cleared.
- Address decode (on the latched address):
  - cpu_addr[31:28]==4'hF selects IO.
  - Otherwise RAM at word index cpu_addr[ADDR_W+1:2]; upper address bits are aliased.
  - cpu_addr[1:0] is ignored (word access only).
- IO map:
  - 0xF0000000: LED register. A write loads cpu_wdata[7:0]; a read returns {24'b0, led_out}.
  - 0xF0000004: switches. A read returns {24'b0, sw_in}; writes are ignored.
  - Any other IO address reads 0; writes to it are ignored.
- States:
  - IDLE: when cpu_req=1, latch addr/we/wdata. Go to RESP if WAIT_CYCLES==0, else go to WAIT with counter=WAIT_CYCLES.
  - WAIT: decrement the counter each cycle; when the counter reaches 1, go to RESP.
  - RESP:
    - mio_ready=1 for exactly this one cycle.
    - cpu_rdata is loaded on the edge entering RESP: read data for reads, 0 for writes.
    - A write commits (RAM or LED) on the edge leaving RESP.
    - Next state is RELEASE.
  - RELEASE: mio_ready=0; wait for cpu_req=0, then go to IDLE.
- Latency:
  - mio_ready is high during cycle WAIT_CYCLES+1, counting the cycle after the IDLE edge that sampled cpu_req as cycle 1.
  - Minimum spacing between two accesses is WAIT_CYCLES+3 cycles.
- Stability and inputs:
  - Input changes after latching (addr/we/wdata) are ignored until the next IDLE.
  - cpu_rdata holds its value until the next RESP entry.
  - cpu_req deasserted in WAIT does not abort the access; it still completes.
- Reset mid-operation: if reset asserts in WAIT or RESP before the commit edge, no write occurs and the state returns to IDLE.
- Read-after-write to the same address returns the newly written data; the RAM has no bypass hazard because accesses are serialized.

Optional Feature:
- Macro: MIO_TIMER_EN.
- Defined:
  - Adds a 32-bit free-running cycle counter, cleared by reset and incremented every clk.
  - Read-only at 0xF0000008; the value returned is the count latched on the IDLE edge that accepted the request.
- Undefined: 0xF0000008 reads 0, like any unmapped IO address, and no counter logic is synthesized.

Test Plan:
- Write then read, WAIT_CYCLES=2: write 0x12345678 to 0x00000008, drop req, then read 0x00000008.
  - Each access gives mio_ready high in cycle 3 after acceptance.
  - The read returns cpu_rdata=0x12345678.
- WAIT_CYCLES=0 and cpu_req held high continuously:
  - mio_ready pulses exactly once per access.
  - No second access starts until req drops (RELEASE state).
- IO access: write 0xFFFFFFA5 to 0xF0000000, giving led_out=0xA5 and a readback of 0x000000A5. With sw_in=0x3C, a read of 0xF0000004 returns 0x0000003C.
- Reset mid-WAIT during a write of 0xDEADBEEF to 0x10:
  - mio_ready never pulses.
  - After reset releases, a read of 0x10 returns the prior contents, not 0xDEADBEEF.
- Aliasing and alignment, ADDR_W=10: a write to 0x00001004 followed by a read of 0x00000007 returns the same word.
- With MIO_TIMER_EN defined: two reads of 0xF0000008 accepted 20 cycles apart return values that differ by 20. Without the macro, both reads return 0.
